// File: rtl/mem_access_ctrl_if.sv
// Processor request/response and memory bus bundle for mem_access_ctrl.
// slave: the controller side; master: the processor plus memory side.
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_read_write;
    logic        mem_enable;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_error,
               mem_address, mem_wdata, mem_read_write, mem_enable
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_error,
               mem_address, mem_wdata, mem_read_write, mem_enable
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Byte/half/word load-store controller in front of a single-port 32-bit memory.
// Sub-word stores are done as read-modify-write; bad accesses are rejected
// without touching the memory.
module mem_access_ctrl #(
    parameter logic [31:0] MEM_START = 32'h8002_0000,
    parameter int unsigned MEM_DEPTH = 262144
) (
    input  logic clock,
    input  logic reset_n,
    mem_access_ctrl_if.slave bus
);
    localparam logic [31:0] MEM_DEPTH_W = 32'(MEM_DEPTH);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic        wr_q, sgn_q, err_q;
    logic [1:0]  size_q, lane_q;
    logic [31:0] wdata_q, word_q, maddr_q;

    logic        accept, req_err;
    logic [31:0] offset;
    logic [4:0]  sh;
    logic [31:0] shifted, load_word, store_word, lane_mask, ins_data;

    assign accept = bus.req_valid && (state_q == IDLE);
    assign offset = bus.req_addr - MEM_START;

    // Reject illegal size, misalignment and addresses outside the memory window
    always_comb begin
        req_err = 1'b0;
        if (bus.req_size == 2'b11)                             req_err = 1'b1;
        if (bus.req_size == 2'b01 && bus.req_addr[0])          req_err = 1'b1;
        if (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
        if (bus.req_addr < MEM_START)                          req_err = 1'b1;
        if ((offset >> 2) >= MEM_DEPTH_W)                      req_err = 1'b1;
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Request latch, memory address register and read-data capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= 1'b0;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= '0;
            lane_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            maddr_q <= '0;
        end else begin
            if (accept) begin
                wr_q    <= bus.req_write;
                sgn_q   <= bus.req_signed;
                err_q   <= req_err;
                size_q  <= bus.req_size;
                lane_q  <= bus.req_addr[1:0];
                wdata_q <= bus.req_wdata;
                // Rejected requests leave the memory address untouched
                if (!req_err) maddr_q <= {bus.req_addr[31:2], 2'b00};
            end
            if (state_q == READ) word_q <= bus.mem_rdata;
        end
    end

    // Lane extraction for loads and lane merge for sub-word stores
    always_comb begin
        sh      = {lane_q, 3'b000};
        shifted = word_q >> sh;
        case (size_q)
            2'b00:   load_word = {{24{sgn_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_word = {{16{sgn_q & shifted[15]}}, shifted[15:0]};
            default: load_word = word_q;
        endcase
        lane_mask = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
        ins_data  = (wdata_q & ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF)) << sh;
        if (size_q == 2'b10) store_word = wdata_q;
        else                 store_word = (word_q & ~lane_mask) | ins_data;
    end

    assign bus.mem_address = maddr_q;

    // Next-state and output decode
    always_comb begin
        state_d            = state_q;
        bus.req_ready      = 1'b0;
        bus.resp_valid     = 1'b0;
        bus.resp_error     = 1'b0;
        bus.resp_rdata     = '0;
        bus.mem_enable     = 1'b0;
        bus.mem_read_write = 1'b1;
        bus.mem_wdata      = '0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (req_err)                                   state_d = RESP;
                    else if (bus.req_write && bus.req_size == 2'b10) state_d = WRITE;
                    else                                           state_d = READ;
                end
            end
            READ: begin
                bus.mem_enable = 1'b1;
                state_d        = wr_q ? WRITE : RESP;
            end
            WRITE: begin
                bus.mem_enable     = 1'b1;
                bus.mem_read_write = 1'b0;
                bus.mem_wdata      = store_word;
                state_d            = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_error = err_q;
                if (!err_q && !wr_q) bus.resp_rdata = load_word;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter MEM_START, default 32'h8002_0000, byte address of memory word 0.
REQ-002 Parameter MEM_DEPTH, default 262144, number of 32-bit words in the attached memory.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  processor access request present.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 resp_valid  output  1  one-cycle completion pulse.
REQ-013 resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-014 resp_error  output  1  qualifies resp_valid; access rejected.
REQ-015 mem_address  output  32  byte address to memory, word-aligned (bits [1:0] = 00).
REQ-016 mem_wdata  output  32  write data to memory.
REQ-017 mem_read_write  output  1  1 = read, 0 = write.
REQ-018 mem_enable  output  1  memory access strobe.
REQ-019 mem_rdata  input  32  memory read data, combinationally valid while mem_enable and mem_read_write are high.

Function
REQ-020 States SHALL be IDLE, READ, WRITE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 A request SHALL be accepted on a rising edge with req_valid and req_ready high; all req_* fields are latched at that edge.
REQ-022 Error check at acceptance: req_size = 11; half with addr[0] = 1; word with addr[1:0] != 00; addr < MEM_START; (addr - MEM_START) >> 2 >= MEM_DEPTH (32-bit unsigned arithmetic).
REQ-023 Erroneous request: IDLE -> RESP; no mem_enable; resp_error = 1, resp_rdata = 0.
REQ-024 Load: IDLE -> READ -> RESP; word store: IDLE -> WRITE -> RESP; byte/half store: IDLE -> READ -> WRITE -> RESP (read-modify-write).
REQ-025 READ: mem_enable = 1, mem_read_write = 1, mem_address = {req_addr[31:2], 2'b00}; mem_rdata captured at the edge leaving READ.
REQ-026 WRITE: mem_enable = 1, mem_read_write = 0, same mem_address; the memory commits on the edge leaving WRITE.
REQ-027 Little-endian byte lanes: lane = addr[1:0]; byte lane k = bits [8k+7:8k]; half at addr[1] = 0 uses [15:0], at addr[1] = 1 uses [31:16].
REQ-028 Sub-word store merge: mem_wdata = captured word with the addressed lane(s) replaced by req_wdata[7:0] or [15:0]; other lanes unchanged.
REQ-029 Word store: mem_wdata = req_wdata.
REQ-030 Load result: addressed lane(s) shifted to bit 0, then sign- or zero-extended per req_signed; word loads ignore req_signed.
REQ-031 RESP: resp_valid = 1 for exactly one cycle, then IDLE; no back-pressure on the response.
REQ-032 Outside READ/WRITE: mem_enable = 0, mem_read_write = 1, mem_wdata = 0; mem_address holds its last value.
REQ-033 Latency from accept edge to resp_valid high: error 1 cycle, load 2, word store 2, sub-word store 3.
REQ-034 mem_enable SHALL never be high for more than one consecutive cycle of the same direction per request.

Reset
REQ-035 reset_n low SHALL immediately force IDLE, req_ready = 1 once released, resp_valid = 0, resp_error = 0, resp_rdata = 0, mem_enable = 0, mem_read_write = 1, mem_address = 0, mem_wdata = 0.
REQ-036 Reset asserted in READ or WRITE SHALL abort the request; mem_enable drops asynchronously, no write is committed, and no response is produced.

Verification
REQ-037 Word store 32'hDEADBEEF to 32'h8002_0010, then word load same address -> WRITE one cycle with mem_wdata = 32'hDEADBEEF; load resp_rdata = 32'hDEADBEEF 2 cycles after accept.
REQ-038 Memory word 32'h11223344, byte store 8'hAA to 32'h8002_0011 -> READ, then WRITE with mem_wdata = 32'h1122AA44; resp_valid 3 cycles after accept.
REQ-039 Memory word 32'h80FF7F01, signed byte load at 32'h8002_0003 -> resp_rdata = 32'hFFFFFF80; unsigned half load at 32'h8002_0002 -> 32'h000080FF.
REQ-040 Word load at 32'h8002_0002, half store at 32'h8001_FFFE, any size-11 request, word load at 32'h8012_0000 -> resp_error = 1 one cycle after accept; mem_enable never asserted.
REQ-041 reset_n pulled low during the WRITE cycle of a byte store -> mem_enable 0 immediately; memory content unchanged; no resp_valid; next request is accepted normally.
